dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the CPU MEM stage and a DMA requester.
- Sits between the EX/MEM pipeline register outputs (ALU result used as the address, rs2 data used as the store data) and the data memory.
- Sequences one access at a time with a fixed-latency counter.
- Drives cpu_stall to hold the pipeline until the CPU access completes.
- CPU has priority; a starvation counter guarantees DMA forward progress.

Parameters:
- DATA_W, 32, data width of all data buses.
- ADDR_W, 32, byte-address width.
- MEM_LAT, 2, cycles from issue to access completion (>=1).
- STARVE_MAX, 4, consecutive CPU wins against a pending DMA request before DMA is forced to win.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- cpu_req  in  1  MEM-stage load/store request; held with its payload until cpu_stall falls.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_W  byte address (from the EX/MEM ALU result).
- cpu_wdata  in  DATA_W  store data (from the EX/MEM rs2 data).
- cpu_wstrb  in  DATA_W/8  byte enables for stores.
- cpu_stall  out  1  pipeline hold.
- cpu_rdata  out  DATA_W  load data, valid in the CPU completion cycle.
- dma_req  in  1  DMA request; held with its payload until dma_done.
- dma_we  in  1  1 = write, 0 = read.
- dma_addr  in  ADDR_W  byte address.
- dma_wdata  in  DATA_W  write data.
- dma_wstrb  in  DATA_W/8  byte enables for writes.
- dma_gnt  out  1  pulse in the DMA issue cycle.
- dma_done  out  1  pulse in the DMA completion cycle.
- dma_rdata  out  DATA_W  read data, valid when dma_done=1.
- mem_en  out  1  memory access strobe (issue cycle only).
- mem_we  out  DATA_W/8  byte write enables; 0 for reads.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the issue cycle.

Behaviour:
- FSM states:
  - IDLE: no access outstanding.
  - ACCESS: one access outstanding; owner register (CPU/DMA) and lat_cnt valid.
- IDLE, arbitration (combinational, in the issue cycle):
  - cpu_req only -> CPU wins.
  - dma_req only -> DMA wins.
  - Both requests -> CPU wins unless starve_cnt==STARVE_MAX, in which case DMA wins.
- IDLE, issue cycle (a winner exists):
  - mem_en=1; mem_addr, mem_wdata from the winner; mem_we = winner_we ? winner_wstrb : 0.
  - Owner latched; lat_cnt <= MEM_LAT-1; next state ACCESS.
  - dma_gnt=1 if DMA won.
- IDLE with no request: mem_en=0, mem_we=0, mem_addr/mem_wdata=0.
- ACCESS:
  - mem_en=0, mem_we=0.
  - lat_cnt decrements each cycle.
  - Completion cycle is lat_cnt==0, i.e. issue cycle + MEM_LAT.
  - In the completion cycle: owner CPU -> cpu_stall=0; owner DMA -> dma_done=1.
  - Next state after completion is IDLE. No back-to-back issue: throughput is one access per MEM_LAT+1 cycles.
- cpu_stall = cpu_req && !(state==ACCESS && owner==CPU && lat_cnt==0). cpu_req=0 always gives cpu_stall=0.
- cpu_rdata and dma_rdata are both driven directly from mem_rdata; they are only meaningful in the owner's completion cycle.
- Stores complete on the same schedule as loads.
- starve_cnt, width clog2(STARVE_MAX+1), updated at issue:
  - CPU wins while dma_req=1 -> increment, saturating at STARVE_MAX.
  - DMA wins -> cleared to 0.
  - Otherwise held.
- Requests that drop before completion are a protocol violation. The access still completes; the completion pulse is still generated.
- Reset (rst=0, asynchronous):
  - state=IDLE, owner=CPU, lat_cnt=0, starve_cnt=0.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, dma_gnt=0, dma_done=0.
  - cpu_stall follows cpu_req.
  - Any outstanding access is abandoned; no completion pulse is generated for it after reset release.
- After rst rises, arbitration resumes on the first clock edge.

Decomposition:
- Shared package holds:
  - FSM state encoding (ST_IDLE, ST_ACCESS).
  - Owner encoding (OWN_CPU, OWN_DMA).
  - Defaults DATA_W=32, ADDR_W=32.
- Sub-module: dmem_arb_starve, the saturating starvation counter with win/pending inputs and a force_dma output.
- FSM, latency counter and datapath muxing stay in dmem_arbiter.

Test Plan (MEM_LAT=2, STARVE_MAX=4):
- CPU load alone: cpu_req=1, cpu_we=0, addr 0x100, mem_rdata=0xDEADBEEF.
  - Issue cycle T: mem_en=1, mem_we=0.
  - cpu_stall=1 at T and T+1, 0 at T+2; cpu_rdata=0xDEADBEEF at T+2.
- CPU store: addr 0x104, wdata 0x12345678, wstrb 0xF.
  - Issue cycle: mem_we=0xF, mem_wdata=0x12345678.
  - cpu_stall falls at T+2.
  - No re-issue until T+3.
- DMA read alone: addr 0x200.
  - dma_gnt at T; dma_done at T+2 with dma_rdata=mem_rdata.
  - cpu_stall stays 0 throughout.
- Simultaneous cpu_req and dma_req held continuously:
  - Grant order CPU, CPU, CPU, CPU, DMA, CPU...
  - starve_cnt reaches 4, then clears on the DMA grant.
- rst pulled low at T+1 of a CPU load:
  - mem_en=0 and state IDLE immediately.
  - No completion at T+2.
  - After rst=1 the held cpu_req re-issues on the next edge; stall is released MEM_LAT cycles later.
- Starvation saturation: 6 CPU-only requests with dma_req=0.
  - starve_cnt stays 0.
  - Then dma_req asserted with cpu_req also held: CPU wins; starve_cnt=1.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_pkg : shared encodings and defaults for the data-memory arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dmem_arbiter_pkg;

  localparam int c_data_w_default = 32;
  localparam int c_addr_w_default = 32;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  typedef enum logic [0:0] {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

endpackage

`default_nettype wire

// File: rtl/dmem_arb_starve.sv
// ---------------------------------------------------------------------------
// dmem_arb_starve : saturating count of CPU wins over a waiting DMA request
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dmem_arb_starve
  import dmem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic issue,
  input  logic cpu_win,
  input  logic dma_pending,
  output logic force_dma
);

  localparam int c_cnt_w = $clog2(STARVE_MAX + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(STARVE_MAX);

  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (issue) begin
      if (!cpu_win) begin
        r_cnt <= '0;
      end else if (dma_pending && (r_cnt != c_cnt_max)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign force_dma = (r_cnt == c_cnt_max);

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter : shares a single-port data memory between CPU MEM stage and DMA
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_W     = c_data_w_default,
  parameter int ADDR_W     = c_addr_w_default,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [DATA_W/8-1:0] cpu_wstrb,
  output logic                cpu_stall,
  output logic [DATA_W-1:0]   cpu_rdata,
  input  logic                dma_req,
  input  logic                dma_we,
  input  logic [ADDR_W-1:0]   dma_addr,
  input  logic [DATA_W-1:0]   dma_wdata,
  input  logic [DATA_W/8-1:0] dma_wstrb,
  output logic                dma_gnt,
  output logic                dma_done,
  output logic [DATA_W-1:0]   dma_rdata,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int c_lat_w = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_t             r_state;
  owner_t             r_owner;
  logic [c_lat_w-1:0] r_lat_cnt;

  logic w_force_dma;
  logic w_idle;
  logic w_cpu_win;
  logic w_dma_win;
  logic w_issue;
  logic w_done;

  // Gating with rst keeps the memory strobe quiet while reset is held.
  assign w_idle    = rst && (r_state == ST_IDLE);
  assign w_dma_win = w_idle && dma_req && (!cpu_req || w_force_dma);
  assign w_cpu_win = w_idle && cpu_req && !w_dma_win;
  assign w_issue   = w_cpu_win || w_dma_win;
  assign w_done    = (r_state == ST_ACCESS) && (r_lat_cnt == '0);

  dmem_arb_starve #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk         (clk),
    .rst         (rst),
    .issue       (w_issue),
    .cpu_win     (w_cpu_win),
    .dma_pending (dma_req),
    .force_dma   (w_force_dma)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_owner   <= OWN_CPU;
      r_lat_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            r_state   <= ST_ACCESS;
            r_owner   <= w_dma_win ? OWN_DMA : OWN_CPU;
            r_lat_cnt <= c_lat_w'(MEM_LAT - 1);
          end
        end
        ST_ACCESS: begin
          if (r_lat_cnt == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_en    = w_issue;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_cpu_win) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we ? cpu_wstrb : '0;
    end else if (w_dma_win) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_we    = dma_we ? dma_wstrb : '0;
    end
  end

  assign dma_gnt   = w_dma_win;
  assign dma_done  = w_done && (r_owner == OWN_DMA);
  assign cpu_stall = cpu_req && !(w_done && (r_owner == OWN_CPU));
  assign cpu_rdata = mem_rdata;
  assign dma_rdata = mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter : directed self-checking bench for dmem_arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [3:0]  cpu_wstrb = '0;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic        dma_req = 1'b0;
  logic        dma_we = 1'b0;
  logic [31:0] dma_addr = '0;
  logic [31:0] dma_wdata = '0;
  logic [3:0]  dma_wstrb = '0;
  logic        dma_gnt;
  logic        dma_done;
  logic [31:0] dma_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(
    .DATA_W     (32),
    .ADDR_W     (32),
    .MEM_LAT    (2),
    .STARVE_MAX (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_wstrb (cpu_wstrb),
    .cpu_stall (cpu_stall),
    .cpu_rdata (cpu_rdata),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_wstrb (dma_wstrb),
    .dma_gnt   (dma_gnt),
    .dma_done  (dma_done),
    .dma_rdata (dma_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] obs;
    rst = 1'b0;
    #2;
    obs = {mem_en, mem_we, dma_gnt, cpu_stall};
    checks++;
    if (obs !== 7'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || dma_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: {en,we,gnt,stall}=%b addr=%h wdata=%h done=%b required all zero",
               obs, mem_addr, mem_wdata, dma_done);
    end
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'h55; cpu_wstrb = 4'hF;
    dma_req = 1'b1; dma_addr = 32'h20;
    next_cycle();
    obs = {mem_en, mem_we, dma_gnt, cpu_stall};
    checks++;
    if (obs !== 7'b0000001 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_held_req: {en,we,gnt,stall}=%b addr=%h wdata=%h required 0000001 0 0",
               obs, mem_addr, mem_wdata);
    end
    cpu_req = 1'b0; cpu_we = 1'b0; dma_req = 1'b0;
    #1;
    checks++;
    if (cpu_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall_follows: stall=%b required 0", cpu_stall);
    end
    rst = 1'b1;
    next_cycle();
  endtask

  task automatic test_cpu_load();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100; cpu_wstrb = 4'hF;
    mem_rdata = 32'hDEADBEEF;
    #1;
    checks++;
    if ({mem_en, mem_we, cpu_stall, dma_gnt} !== 7'b1000010 || mem_addr !== 32'h100) begin
      errors++;
      $display("FAIL load_issue: en=%b we=%h stall=%b gnt=%b addr=%h required 1 0 1 0 100",
               mem_en, mem_we, cpu_stall, dma_gnt, mem_addr);
    end
    next_cycle();
    checks++;
    if ({mem_en, cpu_stall} !== 2'b01) begin
      errors++;
      $display("FAIL load_t1: en=%b stall=%b required 0 1", mem_en, cpu_stall);
    end
    next_cycle();
    checks++;
    if (cpu_stall !== 1'b0 || cpu_rdata !== 32'hDEADBEEF || dma_done !== 1'b0) begin
      errors++;
      $display("FAIL load_done: stall=%b rdata=%h done=%b required 0 deadbeef 0",
               cpu_stall, cpu_rdata, dma_done);
    end
    next_cycle();
    cpu_req = 1'b0;
    #1;
  endtask

  task automatic test_cpu_store();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h104; cpu_wdata = 32'h12345678; cpu_wstrb = 4'hF;
    #1;
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 4'hF || mem_wdata !== 32'h12345678 || mem_addr !== 32'h104) begin
      errors++;
      $display("FAIL store_issue: en=%b we=%h wdata=%h addr=%h required 1 f 12345678 104",
               mem_en, mem_we, mem_wdata, mem_addr);
    end
    for (int c = 1; c <= 2; c++) begin
      next_cycle();
      checks++;
      if (mem_en !== 1'b0 || mem_we !== 4'h0 || cpu_stall !== (c == 1)) begin
        errors++;
        $display("FAIL store_t%0d: en=%b we=%h stall=%b required 0 0 %b",
                 c, mem_en, mem_we, cpu_stall, (c == 1));
      end
    end
    next_cycle();
    checks++;
    if (mem_en !== 1'b1 || cpu_stall !== 1'b1) begin
      errors++;
      $display("FAIL store_reissue_t3: en=%b stall=%b required 1 1", mem_en, cpu_stall);
    end
    next_cycle();
    next_cycle();
    next_cycle();
    cpu_req = 1'b0; cpu_we = 1'b0;
    #1;
  endtask

  task automatic test_dma_read();
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h200; dma_wstrb = 4'hF;
    mem_rdata = 32'hCAFEF00D;
    #1;
    checks++;
    if ({dma_gnt, mem_en, mem_we, cpu_stall, dma_done} !== 8'b11000000 || mem_addr !== 32'h200) begin
      errors++;
      $display("FAIL dma_issue: gnt=%b en=%b we=%h stall=%b done=%b addr=%h required 1 1 0 0 0 200",
               dma_gnt, mem_en, mem_we, cpu_stall, dma_done, mem_addr);
    end
    next_cycle();
    checks++;
    if ({dma_gnt, dma_done, mem_en, cpu_stall} !== 4'b0000) begin
      errors++;
      $display("FAIL dma_t1: gnt=%b done=%b en=%b stall=%b required 0 0 0 0",
               dma_gnt, dma_done, mem_en, cpu_stall);
    end
    next_cycle();
    checks++;
    if (dma_done !== 1'b1 || dma_rdata !== 32'hCAFEF00D || cpu_stall !== 1'b0) begin
      errors++;
      $display("FAIL dma_done: done=%b rdata=%h stall=%b required 1 cafef00d 0",
               dma_done, dma_rdata, cpu_stall);
    end
    next_cycle();
    dma_req = 1'b0;
    #1;
    checks++;
    if (dma_done !== 1'b0 || mem_en !== 1'b0) begin
      errors++;
      $display("FAIL dma_after: done=%b en=%b required 0 0", dma_done, mem_en);
    end
  endtask

  task automatic test_contention();
    logic [5:0] exp_dma;
    logic       want;
    exp_dma = 6'b010000;  // bit i = grant i goes to DMA
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h300; cpu_wdata = 32'hAAAA5555; cpu_wstrb = 4'h3;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h400; dma_wdata = 32'h0F0F0F0F; dma_wstrb = 4'hC;
    #1;
    for (int i = 0; i < 6; i++) begin
      want = exp_dma[i];
      checks++;
      if (mem_en !== 1'b1 || dma_gnt !== want ||
          mem_addr !== (want ? 32'h400 : 32'h300) || mem_we !== (want ? 4'hC : 4'h3)) begin
        errors++;
        $display("FAIL contend_grant%0d: en=%b gnt=%b addr=%h we=%h required 1 %b %h %h",
                 i, mem_en, dma_gnt, mem_addr, mem_we, want,
                 (want ? 32'h400 : 32'h300), (want ? 4'hC : 4'h3));
      end
      next_cycle();
      next_cycle();
      checks++;
      if (dma_done !== want || cpu_stall !== want) begin
        errors++;
        $display("FAIL contend_done%0d: done=%b stall=%b required %b %b",
                 i, dma_done, cpu_stall, want, want);
      end
      next_cycle();
    end
    cpu_req = 1'b0; dma_req = 1'b0; cpu_we = 1'b0; dma_we = 1'b0;
    #1;
  endtask

  task automatic test_reset_mid_access();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h500;
    #1;
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h500) begin
      errors++;
      $display("FAIL rstmid_issue: en=%b addr=%h required 1 500", mem_en, mem_addr);
    end
    next_cycle();
    rst = 1'b0;
    #1;
    checks++;
    if (mem_en !== 1'b0 || cpu_stall !== 1'b1 || dma_done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_assert: en=%b stall=%b done=%b required 0 1 0", mem_en, cpu_stall, dma_done);
    end
    next_cycle();
    checks++;
    if (cpu_stall !== 1'b1 || mem_en !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_no_completion: stall=%b en=%b required 1 0", cpu_stall, mem_en);
    end
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h500 || cpu_stall !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_reissue: en=%b addr=%h stall=%b required 1 500 1", mem_en, mem_addr, cpu_stall);
    end
    next_cycle();
    checks++;
    if (cpu_stall !== 1'b1 || mem_en !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_t1: stall=%b en=%b required 1 0", cpu_stall, mem_en);
    end
    next_cycle();
    checks++;
    if (cpu_stall !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_release: stall=%b required 0", cpu_stall);
    end
    next_cycle();
    cpu_req = 1'b0;
    #1;
  endtask

  task automatic test_starve_sat();
    logic want;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h600;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'h700;
    #1;
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      next_cycle();
      next_cycle();
    end
    // CPU-only wins must not have advanced the counter: four more CPU wins, then DMA.
    dma_req = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      want = (i == 4);
      checks++;
      if (mem_en !== 1'b1 || dma_gnt !== want || mem_addr !== (want ? 32'h700 : 32'h600)) begin
        errors++;
        $display("FAIL starve_grant%0d: en=%b gnt=%b addr=%h required 1 %b %h",
                 i, mem_en, dma_gnt, mem_addr, want, (want ? 32'h700 : 32'h600));
      end
      next_cycle();
      next_cycle();
      next_cycle();
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cpu_load();
    test_cpu_store();
    test_dma_read();
    test_contention();
    test_reset_mid_access();
    test_starve_sat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
